lb_step_sequencer: RTL and testbench

Controller between the HPS-facing 32-bit PIO registers and the lattice-Boltzmann step engine. HPS writes a parameter word and a command word, then flips a toggle bit in the command word. The sequencer latches the parameter, issues N single-step start pulses to the accelerator, and counts the done pulses. It reports progress and completion back through a status word that feeds a to-HPS PIO, and it supports abort and a per-step timeout.

---
 rtl/lb_step_sequencer.sv | 116 +++++++++++
 tb/tb_lb_step_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_step_sequencer.sv
// Sequencer between the HPS PIO registers and the lattice-Boltzmann step engine:
// latches a parameter, issues N single-step starts, counts dones, reports status.
module lb_step_sequencer #(
    parameter int STEP_W    = 16,
    parameter int TIMEOUT_W = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    input  logic [31:0] param_word,
    output logic        acc_start,
    output logic [31:0] acc_param,
    input  logic        acc_done,
    output logic [31:0] status_word
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    localparam logic [TIMEOUT_W-1:0] TIMER_MAX = {TIMEOUT_W{1'b1}};

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 go_prev;
    logic                 go_edge;
    logic                 abort;
    logic [STEP_W-1:0]    cmd_total;
    logic [STEP_W-1:0]    total;
    logic [STEP_W-1:0]    done_cnt;
    logic [STEP_W-1:0]    done_inc;
    logic [TIMEOUT_W-1:0] timer;
    logic                 ack_bit;
    logic                 timeout_flag;
    logic                 aborted_flag;
    logic                 busy;
    logic [15:0]          steps_ext;
    logic                 unused_cmd_bits;

    assign go_edge   = cmd_word[0] ^ go_prev;
    assign abort     = cmd_word[1];
    assign cmd_total = cmd_word[16 +: STEP_W];
    assign done_inc  = done_cnt + 1'b1;
    assign busy      = (state != S_IDLE);
    assign acc_start = (state == S_START);

    assign unused_cmd_bits = ^cmd_word[15:2];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go_edge) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (cmd_total == '0) ? S_ACK : S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                // Abort outranks a coincident done; the timeout is the last resort.
                if (abort)
                    state_nxt = S_ACK;
                else if (acc_done)
                    state_nxt = (done_inc == total) ? S_ACK : S_START;
                else if (timer == TIMER_MAX)
                    state_nxt = S_ACK;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            go_prev      <= 1'b0;
            acc_param    <= '0;
            total        <= '0;
            done_cnt     <= '0;
            timer        <= '0;
            ack_bit      <= 1'b0;
            timeout_flag <= 1'b0;
            aborted_flag <= 1'b0;
        end else begin
            state   <= state_nxt;
            go_prev <= cmd_word[0];
            case (state)
                S_LOAD: begin
                    acc_param    <= param_word;
                    total        <= cmd_total;
                    done_cnt     <= '0;
                    timeout_flag <= 1'b0;
                    aborted_flag <= 1'b0;
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (abort)
                        aborted_flag <= 1'b1;
                    else if (acc_done)
                        done_cnt <= done_inc;
                    else if (timer == TIMER_MAX)
                        timeout_flag <= 1'b1;
                end
                S_ACK: ack_bit <= ~ack_bit;
                default: ;
            endcase
        end
    end

    always_comb begin
        steps_ext = '0;
        steps_ext[STEP_W-1:0] = done_cnt;
    end

    assign status_word = {steps_ext, 12'b0, aborted_flag, timeout_flag, busy, ack_bit};

endmodule

// File: tb/tb_lb_step_sequencer.sv
// Bench for lb_step_sequencer: directed runs, an accelerator model returning dones,
// and a monitor that checks the status word at every ack toggle against a queue.
module tb_lb_step_sequencer;

    logic        clk;
    logic        reset_n;
    logic [31:0] cmd_word;
    logic [31:0] param_word;
    logic        acc_start;
    logic [31:0] acc_param;
    logic        acc_done;
    logic [31:0] status_word;

    logic        go_bit;
    logic        abort_drv;
    logic        abort_acc;
    logic [15:0] count_v;
    logic        acc_en;
    logic        exp_ack;
    int          n_done;
    int          abort_at;
    int          cd;
    int          n_cmp;
    int          n_err;

    // {starts[7:0], param[31:0], status[31:0]}
    logic [71:0] exp_q[$];

    assign cmd_word = {count_v, 14'b0, abort_drv | abort_acc, go_bit};

    lb_step_sequencer #(.STEP_W(16), .TIMEOUT_W(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_word(cmd_word),
        .param_word(param_word),
        .acc_start(acc_start),
        .acc_param(acc_param),
        .acc_done(acc_done),
        .status_word(status_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accelerator model: one acc_done four cycles after each acc_start.
    initial begin
        acc_done  = 1'b0;
        abort_acc = 1'b0;
        cd        = 0;
    end
    always @(negedge clk) begin
        acc_done  = 1'b0;
        abort_acc = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                n_done++;
                acc_done = 1'b1;
                if (n_done == abort_at) abort_acc = 1'b1;
            end
        end
        if (acc_start && acc_en) cd = 4;
    end

    // Monitor: each ack toggle retires one expected run.
    logic prev_ack;
    int   seen_starts;
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ack    = 1'b0;
            seen_starts = 0;
        end else begin
            if (acc_start) seen_starts++;
            if (status_word[0] != prev_ack) begin
                logic [71:0] e;
                prev_ack = status_word[0];
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ack: status 0x%08h with no run outstanding", status_word);
                end else begin
                    e = exp_q.pop_front();
                    check("run_status", status_word, e[31:0]);
                    check("run_param", acc_param, e[63:32]);
                    check("run_starts", 32'(seen_starts), {24'b0, e[71:64]});
                end
                seen_starts = 0;
            end
        end
    end

    task automatic kick(input logic [15:0] cnt, input logic [31:0] prm);
        count_v    = cnt;
        param_word = prm;
        go_bit     = ~go_bit;
    endtask

    task automatic push_exp(input int starts, input logic [31:0] prm, input logic [15:0] steps,
                            input logic to, input logic ab);
        exp_ack = ~exp_ack;
        exp_q.push_back({8'(starts), prm, steps, 12'b0, ab, to, 1'b0, exp_ack});
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!status_word[1]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: busy still 1 after 300 cycles", name);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev;
        int   base;
        int   starts_after;
        bit   got;
        n_cmp      = 0;
        n_err      = 0;
        n_done     = 0;
        abort_at   = -1;
        reset_n    = 1'b0;
        go_bit     = 1'b0;
        abort_drv  = 1'b0;
        count_v    = '0;
        param_word = '0;
        acc_en     = 1'b1;
        exp_ack    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_status", status_word, 32'h0);
        check("reset_start", {31'b0, acc_start}, 32'h0);
        check("reset_param", acc_param, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Three steps: start appears two cycles after the go edge.
        kick(16'd3, 32'hDEADBEEF);
        push_exp(3, 32'hDEADBEEF, 16'd3, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("go_lat_load", {31'b0, acc_start}, 32'h0);
        @(posedge clk); #1;
        check("go_lat_start", {31'b0, acc_start}, 32'h1);
        check("param_latched", acc_param, 32'hDEADBEEF);
        wait_idle("run3");

        // Zero count: ack three cycles after the edge, no start pulse.
        prev = exp_ack;
        kick(16'd0, 32'h12345678);
        push_exp(0, 32'h12345678, 16'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;
        check("zero_ack_early", {31'b0, status_word[0]}, {31'b0, prev});
        @(posedge clk); #1;
        check("zero_ack_lat", {31'b0, status_word[0]}, {31'b0, ~prev});
        wait_idle("run0");

        // Abort raised after the second done: the third step starts but is not counted.
        base = n_done;
        kick(16'd5, 32'hA5A50001);
        push_exp(3, 32'hA5A50001, 16'd2, 1'b0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (n_done >= base + 2) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL abort_wait: second done not seen, got %0d dones", n_done - base);
        end
        abort_drv = 1'b1;
        wait_idle("abort");
        abort_drv = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Abort coincident with the third done: abort wins, count stays 2.
        abort_at = n_done + 3;
        kick(16'd5, 32'hA5A50002);
        push_exp(3, 32'hA5A50002, 16'd2, 1'b0, 1'b1);
        wait_idle("abort_coinc");
        abort_at = -1;

        // No done ever returned: watchdog fires on the first step.
        acc_en = 1'b0;
        kick(16'd2, 32'h0BADF00D);
        push_exp(1, 32'h0BADF00D, 16'd0, 1'b1, 1'b0);
        wait_idle("timeout");
        acc_en = 1'b1;

        // Go toggled twice while busy: one run only; flags from the timeout run clear.
        kick(16'd3, 32'h00C0FFEE);
        push_exp(3, 32'h00C0FFEE, 16'd3, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        go_bit = ~go_bit;
        repeat (5) @(posedge clk); #1;
        go_bit = ~go_bit;
        wait_idle("busy_toggle");
        kick(16'd1, 32'h11112222);
        push_exp(1, 32'h11112222, 16'd1, 1'b0, 1'b0);
        wait_idle("after_toggle");

        // Reset in WAIT clears outputs at once; no ack is produced.
        kick(16'd3, 32'h55AA55AA);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (acc_start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL rst_run_start: no acc_start within 20 cycles");
        end
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_status", status_word, 32'h0);
        check("rst_async_start", {31'b0, acc_start}, 32'h0);
        check("rst_async_param", acc_param, 32'h0);
        exp_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        starts_after = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (acc_start) starts_after++;
        end
        check("rst_stays_idle", status_word, 32'h0);
        check("rst_no_start", 32'(starts_after), 32'h0);

        repeat (4) @(posedge clk); #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
